// File: rtl/sine_sequencer.sv
// sine_sequencer
// -----------------------------------------------------------------------------
// Phase-accumulator controller for the quarter-wave sine memory. A programmable
// tuning word is added to the phase accumulator every clock while running. The
// top bits of the accumulator select the memory quadrant and table index.
// Tuning-word changes and stop requests are deferred to the accumulator wrap,
// so the DAC waveform is never cut mid-period.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        single-cycle request to begin/resume output
//   stop         single-cycle request to halt at the end of the current period
//   tw_data      new tuning word (ACC_WIDTH bits)
//   tw_valid     tw_data is offered
//   tw_ready     one-deep pending buffer is empty (accept = tw_valid && tw_ready)
//   read_address table index to memory, acc[ACC_WIDTH-3:ACC_WIDTH-9]
//   read_state   quadrant to memory, acc[ACC_WIDTH-1:ACC_WIDTH-2]
//   sample_valid memory read_data is valid this cycle (running delayed)
//   running      sequencer is in RUN or DRAIN
//   period_done  one-cycle pulse in the cycle whose step wraps the accumulator
// -----------------------------------------------------------------------------
module sine_sequencer #(
  parameter int                   ACC_WIDTH   = 16,
  parameter logic [ACC_WIDTH-1:0] DEFAULT_TW  = ACC_WIDTH'(2**(ACC_WIDTH-9)),
  parameter int                   MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [ACC_WIDTH-1:0] tw_data,
  input  logic                 tw_valid,
  output logic                 tw_ready,
  output logic [6:0]           read_address,
  output logic [1:0]           read_state,
  output logic                 sample_valid,
  output logic                 running,
  output logic                 period_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   tw_active;
  logic [ACC_WIDTH-1:0]   tw_pending;
  logic                   pend_full;
  logic [MEM_LATENCY-1:0] valid_pipe;

  logic [ACC_WIDTH:0]     sum;
  logic                   carry;
  logic                   tw_accept;
  logic                   tw_zero;

  // One extra bit on the adder gives the wrap as its carry out.
  assign sum       = {1'b0, acc} + {1'b0, tw_active};
  assign carry     = sum[ACC_WIDTH];
  assign tw_accept = tw_valid && !pend_full;
  assign tw_zero   = (tw_active == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Stop wins over a simultaneous start. With a zero tuning
  // word the accumulator can never wrap, so stop halts immediately instead of
  // draining forever.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (stop) state_next = tw_zero ? S_IDLE : S_DRAIN;
      end
      S_DRAIN: begin
        if (start && !stop) state_next = S_RUN;
        else if (carry)     state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs. period_done is decoded from registers only (state, acc,
  // tw_active), so there is no input-to-output path.
  always_comb begin
    running     = (state != S_IDLE);
    period_done = (state != S_IDLE) && carry;
  end

  // Phase accumulator: held at zero in IDLE, on the IDLE->RUN edge, and on any
  // edge that returns to IDLE, so a restart always begins at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (state == S_IDLE || state_next == S_IDLE) begin
      acc <= '0;
    end else begin
      acc <= sum[ACC_WIDTH-1:0];
    end
  end

  // Tuning-word handling. In IDLE a word goes straight to the active register.
  // While running it is parked in the one-deep buffer and swapped in at the
  // wrap. A wrap with the buffer full cannot coincide with an accept, because
  // tw_ready is low while the buffer is full; a word accepted in a wrap cycle
  // therefore lands in the empty buffer and waits for the following wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tw_active  <= DEFAULT_TW;
      tw_pending <= '0;
      pend_full  <= 1'b0;
    end else if (state == S_IDLE) begin
      if (tw_accept) tw_active <= tw_data;
    end else if (period_done && pend_full) begin
      tw_active <= tw_pending;
      pend_full <= 1'b0;
    end else if (tw_accept) begin
      tw_pending <= tw_data;
      pend_full  <= 1'b1;
    end
  end

  // sample_valid tracks running through a plain delay line matching the
  // memory read latency, independent of FSM transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= running;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign tw_ready     = !pend_full;
  assign read_address = acc[ACC_WIDTH-3:ACC_WIDTH-9];
  assign read_state   = acc[ACC_WIDTH-1:ACC_WIDTH-2];
  assign sample_valid = valid_pipe[MEM_LATENCY-1];

endmodule

// File: tb/tb_sine_sequencer.sv
// tb_sine_sequencer
// -----------------------------------------------------------------------------
// Self-checking bench for sine_sequencer. A behavioural model tracks the phase
// as an integer, the halt request as a flag and the pending word as a value
// plus flag, and predicts every output each cycle. Scenario tasks drive
// directed and randomized stimulus and compare against the model and against
// hand-derived constants.
// -----------------------------------------------------------------------------
module tb_sine_sequencer;

  localparam int     W   = 16;
  localparam int     LAT = 1;
  localparam longint MOD = 64'd1 << W;
  localparam logic [12:0] RST_VEC = 13'b1_0000000_00_0_0_0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] tw_data = '0;
  logic         tw_valid = 1'b0;
  logic         tw_ready;
  logic [6:0]   read_address;
  logic [1:0]   read_state;
  logic         sample_valid;
  logic         running;
  logic         period_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  longint      m_phase;
  int unsigned m_tw;
  int unsigned m_pend;
  bit          m_running;
  bit          m_halting;
  bit          m_has_pend;
  bit          m_sv;
  bit          sv_q[$];

  sine_sequencer #(.ACC_WIDTH(W), .MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .tw_data      (tw_data),
    .tw_valid     (tw_valid),
    .tw_ready     (tw_ready),
    .read_address (read_address),
    .read_state   (read_state),
    .sample_valid (sample_valid),
    .running      (running),
    .period_done  (period_done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase    = 0;
    m_tw       = 128;
    m_pend     = 0;
    m_running  = 0;
    m_halting  = 0;
    m_has_pend = 0;
    m_sv       = 0;
    sv_q.delete();
    for (int i = 0; i < LAT; i++) sv_q.push_back(1'b0);
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  function automatic void model_edge();
    bit wrap   = m_running && (m_phase + longint'(m_tw) >= MOD);
    bit accept = tw_valid && !m_has_pend;
    bit halt   = 0;
    if (!m_running) begin
      if (accept) m_tw = tw_data;
      m_phase = 0;
      if (start) begin
        m_running = 1;
        m_halting = 0;
      end
    end else begin
      if (m_halting) begin
        if (start && !stop) m_halting = 0;
        else if (wrap)      halt = 1;
      end else if (stop) begin
        if (m_tw == 0) halt = 1;
        else           m_halting = 1;
      end
      m_phase = (m_phase + longint'(m_tw)) % MOD;
      if (wrap && m_has_pend) begin
        m_tw       = m_pend;
        m_has_pend = 0;
      end else if (accept) begin
        m_pend     = tw_data;
        m_has_pend = 1;
      end
      if (halt) begin
        m_running = 0;
        m_halting = 0;
        m_phase   = 0;
      end
    end
    sv_q.push_back(m_running);
    m_sv = sv_q.pop_front();
  endfunction

  // Expected {tw_ready, read_address, read_state, sample_valid, running, period_done}.
  function automatic logic [12:0] exp_vec();
    longint addr = (m_phase >> (W - 9)) & 127;
    longint quad = m_phase >> (W - 2);
    bit     pd   = m_running && (m_phase + longint'(m_tw) >= MOD);
    return {~m_has_pend, 7'(addr), 2'(quad), m_sv, m_running, pd};
  endfunction

  function automatic logic [12:0] dut_vec();
    return {tw_ready, read_address, read_state, sample_valid, running, period_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; tw_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic load_idle_tw(input logic [W-1:0] v);
    tw_data = v; tw_valid = 1'b1;
    tick();
    tw_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    #2;
    n_checks++;
    if (dut_vec() !== RST_VEC) begin
      n_errors++;
      $display("[TB] FAIL reset_values: got %b expected %b", dut_vec(), RST_VEC);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec() !== RST_VEC) begin
      n_errors++;
      $display("[TB] FAIL reset_held: got %b expected %b", dut_vec(), RST_VEC);
    end
    start = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin
      n_errors++;
      $display("[TB] FAIL reset_release: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_period_boundaries();
    do_reset();
    pulse_start();
    n_checks++;
    if ({running, read_address, sample_valid} !== {1'b1, 7'd0, 1'b0}) begin
      n_errors++;
      $display("[TB] FAIL start_latency: got run=%b addr=%0d sv=%b expected 1 0 0",
               running, read_address, sample_valid);
    end
    for (int k = 1; k <= 520; k++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL period_model step %0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
      if (k == 127 || k == 128 || k == 256 || k == 384 || k == 511 || k == 512) begin
        logic [9:0] want;
        case (k)
          127:     want = {2'b00, 7'd127, 1'b0};
          128:     want = {2'b01, 7'd0,   1'b0};
          256:     want = {2'b10, 7'd0,   1'b0};
          384:     want = {2'b11, 7'd0,   1'b0};
          511:     want = {2'b11, 7'd127, 1'b1};
          default: want = {2'b00, 7'd0,   1'b0};
        endcase
        n_checks++;
        if ({read_state, read_address, period_done} !== want) begin
          n_errors++;
          $display("[TB] FAIL quadrant_step %0d: got %b expected %b",
                   k, {read_state, read_address, period_done}, want);
        end
      end
    end
  endtask

  task automatic test_deferred_tw();
    logic [W-1:0] second;
    bit rdy;
    bit first_wrap = 0;
    bit done = 0;
    int cnt = 0;
    do_reset();
    pulse_start();
    repeat (100) tick();
    tw_data = 16'd256; tw_valid = 1'b1;
    tick();
    n_checks++;
    if (tw_ready !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL tw_accept_ready: got %b expected 0", tw_ready);
    end
    second = 16'($urandom_range(128, 2048));
    tw_data = second;
    for (int i = 0; i < 2000 && !done; i++) begin
      rdy = tw_ready;
      tick();
      if (tw_valid && rdy) tw_valid = 1'b0;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL deferred_model cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (first_wrap) cnt++;
      if (!first_wrap && !period_done) begin
        n_checks++;
        if (tw_ready !== 1'b0) begin
          n_errors++;
          $display("[TB] FAIL second_offer_held cycle %0d: got ready %b expected 0", i, tw_ready);
        end
      end
      if (period_done) begin
        if (!first_wrap) begin
          first_wrap = 1;
          cnt = 0;
        end else begin
          done = 1;
        end
      end
    end
    tw_valid = 1'b0;
    n_checks++;
    if (!done || cnt != 256) begin
      n_errors++;
      $display("[TB] FAIL deferred_period: got %0d cycles (done=%0d) expected 256", cnt, done);
    end
  endtask

  task automatic test_stop_restart();
    int k;
    bit saw_pd = 0;
    do_reset();
    pulse_start();
    repeat (300) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    k = 301;
    while (running && k < 1200) begin
      if (period_done) saw_pd = 1;
      tick();
      k++;
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL stop_model step %0d: got %b expected %b", k, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (k != 512 || !saw_pd || {running, read_address, read_state} !== 10'd0) begin
      n_errors++;
      $display("[TB] FAIL stop_halt: got step %0d pd=%0d run=%b addr=%0d st=%b expected 512 1 0 0 00",
               k, saw_pd, running, read_address, read_state);
    end
    do_reset();
    pulse_start();
    repeat (300) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    repeat (99) tick();
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL restart_model cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL restart_no_halt: got running %b expected 1", running);
    end
  endtask

  task automatic test_zero_tw();
    do_reset();
    load_idle_tw(16'd0);
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if ({running, read_address, period_done} !== {1'b1, 7'd0, 1'b0} || dut_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL zero_frozen cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({running, period_done} !== 2'b00) begin
      n_errors++;
      $display("[TB] FAIL zero_stop: got run=%b pd=%b expected 0 0", running, period_done);
    end
    load_idle_tw(16'd128);
    pulse_start();
    tick();
    n_checks++;
    if (read_address !== 7'd1) begin
      n_errors++;
      $display("[TB] FAIL idle_load_immediate: got addr %0d expected 1", read_address);
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    load_idle_tw(16'd1024);
    pulse_start();
    repeat (200) tick();
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec() !== RST_VEC) begin
      n_errors++;
      $display("[TB] FAIL async_reset: got %b expected %b", dut_vec(), RST_VEC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    pulse_start();
    tick();
    tick();
    n_checks++;
    if (read_address !== 7'd2 || dut_vec() !== exp_vec()) begin
      n_errors++;
      $display("[TB] FAIL reset_default_tw: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_simultaneous();
    int k;
    int cnt;
    do_reset();
    pulse_start();
    repeat (50) tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    k = 51;
    n_checks++;
    if (running !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL start_stop_drain: got running %b expected 1", running);
    end
    while (running && k < 1200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k != 512) begin
      n_errors++;
      $display("[TB] FAIL start_stop_halt: got step %0d expected 512", k);
    end
    do_reset();
    pulse_start();
    k = 0;
    while (!period_done && k < 1000) begin
      tick();
      k++;
    end
    tw_data = 16'd512; tw_valid = 1'b1;
    tick();
    tw_valid = 1'b0;
    n_checks++;
    if (tw_ready !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_errors++;
      $display("[TB] FAIL wrap_accept: got %b expected %b", dut_vec(), exp_vec());
    end
    for (int p = 0; p < 2; p++) begin
      cnt = 1;
      while (!period_done && cnt < 1000) begin
        tick();
        cnt++;
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_errors++;
          $display("[TB] FAIL wrap_model cycle %0d: got %b expected %b", cnt, dut_vec(), exp_vec());
        end
      end
      n_checks++;
      if (cnt != (p == 0 ? 512 : 128)) begin
        n_errors++;
        $display("[TB] FAIL wrap_period %0d: got %0d cycles expected %0d", p, cnt, (p == 0 ? 512 : 128));
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      start    = ($urandom % 40) == 0;
      stop     = ($urandom % 60) == 0;
      tw_valid = ($urandom % 8) == 0;
      tw_data  = 16'($urandom_range(256, 4096));
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_errors++;
        $display("[TB] FAIL random_model cycle %0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    start = 1'b0; stop = 1'b0; tw_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_period_boundaries();
    test_deferred_tw();
    test_stop_restart();
    test_zero_tw();
    test_reset_mid_run();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
